// File: rtl/id_stage_scoreboard.sv
// id_stage_scoreboard: decode stage with busy scoreboard, wb bypass, branch resolve and registered ID/EX outputs; ID_PERF_CNT_EN adds stall/issue counters
module id_stage_scoreboard #(
  parameter int DATA_W   = 128,
  parameter int NUM_REGS = 128,
  parameter int REG_AW   = 7,
  parameter int PC_W     = 11,
  parameter int BR_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc_plus8,
  input  logic              in_uses_ra,
  input  logic              in_uses_rb,
  input  logic              in_uses_rc,
  input  logic              in_writes_rt,
  input  logic              in_is_branch,
  input  logic [1:0]        in_imm_sel,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ra,
  output logic [DATA_W-1:0] out_rb,
  output logic [DATA_W-1:0] out_rc,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rt,
  output logic              out_writes_rt,
  output logic [PC_W-1:0]   out_pc_plus8,
  output logic              br_valid,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_target,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_issued
);
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_AW-1:0] ra_a, rb_a, rt_a;
  logic [DATA_W-1:0] ra_d, rb_d, rc_d, imm_d;
  logic [PC_W-1:0] tgt_d;
  logic hazard, issue;
  logic out_valid_q, out_writes_rt_q, br_valid_q, br_taken_q;
  logic [DATA_W-1:0] out_ra_q, out_rb_q, out_rc_q, out_imm_q;
  logic [REG_AW-1:0] out_rt_q;
  logic [PC_W-1:0] out_pc_q, br_target_q;
  logic unused;
  assign unused = ^in_instr[31:25];
  assign rb_a = in_instr[20:14];
  assign ra_a = in_instr[13:7];
  assign rt_a = in_instr[6:0];
  assign ra_d = (wb_en && wb_addr == ra_a) ? wb_data : rf_q[ra_a];
  assign rb_d = (wb_en && wb_addr == rb_a) ? wb_data : rf_q[rb_a];
  assign rc_d = (wb_en && wb_addr == rt_a) ? wb_data : rf_q[rt_a];
  assign hazard = (in_uses_ra   & busy_q[ra_a] & ~(wb_en & (wb_addr == ra_a)))
                | (in_uses_rb   & busy_q[rb_a] & ~(wb_en & (wb_addr == rb_a)))
                | (in_uses_rc   & busy_q[rt_a] & ~(wb_en & (wb_addr == rt_a)))
                | (in_writes_rt & busy_q[rt_a] & ~(wb_en & (wb_addr == rt_a)));
  assign in_ready = ~reset & ~hazard & (~out_valid_q | out_ready);
  assign issue = in_valid & in_ready;
  assign tgt_d = in_pc_plus8 + (imm_d[PC_W-1:0] << BR_SHIFT);
  // immediate extraction and extension by format
  always_comb begin
    imm_d = in_imm_sel == 2'd0 ? {{(DATA_W-7){in_instr[20]}}, in_instr[20:14]}
          : in_imm_sel == 2'd1 ? {{(DATA_W-10){in_instr[23]}}, in_instr[23:14]}
          : in_imm_sel == 2'd2 ? {{(DATA_W-16){in_instr[22]}}, in_instr[22:7]}
          : {{(DATA_W-18){1'b0}}, in_instr[24:7]};
  end
  // scoreboard next state: writeback clears, issuing writer sets (set wins)
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (issue & in_writes_rt) busy_d[rt_a] = 1'b1;
  end
  // register file: single writeback port, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end
  // ID/EX boundary, busy bits and branch resolution
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q          <= '0;
      out_valid_q     <= 1'b0;
      out_ra_q        <= '0;
      out_rb_q        <= '0;
      out_rc_q        <= '0;
      out_imm_q       <= '0;
      out_rt_q        <= '0;
      out_writes_rt_q <= 1'b0;
      out_pc_q        <= '0;
      br_valid_q      <= 1'b0;
      br_taken_q      <= 1'b0;
      br_target_q     <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= issue | (out_valid_q & ~out_ready);
      br_valid_q  <= issue & in_is_branch;
      if (issue) begin
        out_ra_q        <= ra_d;
        out_rb_q        <= rb_d;
        out_rc_q        <= rc_d;
        out_imm_q       <= imm_d;
        out_rt_q        <= rt_a;
        out_writes_rt_q <= in_writes_rt;
        out_pc_q        <= in_pc_plus8;
      end
      if (issue & in_is_branch) begin
        br_taken_q  <= ra_d == rb_d;
        br_target_q <= tgt_d;
      end
    end
  end
  assign out_valid     = out_valid_q;
  assign out_ra        = out_ra_q;
  assign out_rb        = out_rb_q;
  assign out_rc        = out_rc_q;
  assign out_imm       = out_imm_q;
  assign out_rt        = out_rt_q;
  assign out_writes_rt = out_writes_rt_q;
  assign out_pc_plus8  = out_pc_q;
  assign br_valid      = br_valid_q;
  assign br_taken      = br_taken_q;
  assign br_target     = br_target_q;
`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_q, issued_q;
  // saturating stall and issue counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      if (in_valid & ~in_ready & ~&stall_q) stall_q <= stall_q + 32'd1;
      if (issue & ~&issued_q) issued_q <= issued_q + 32'd1;
    end
  end
  assign perf_stall_cycles = stall_q;
  assign perf_issued       = issued_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_issued       = '0;
`endif
endmodule

// File: tb/tb_id_stage_scoreboard.sv
// tb_id_stage_scoreboard: directed stimulus with queued expectations checked by output monitors
module tb_id_stage_scoreboard;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready;
  logic [31:0] in_instr = '0;
  logic [10:0] in_pc_plus8 = '0;
  logic in_uses_ra = 0, in_uses_rb = 0, in_uses_rc = 0, in_writes_rt = 0, in_is_branch = 0;
  logic [1:0] in_imm_sel = '0;
  logic wb_en = 0;
  logic [6:0] wb_addr = '0;
  logic [127:0] wb_data = '0;
  logic out_valid, out_ready = 1;
  logic [127:0] out_ra, out_rb, out_rc, out_imm;
  logic [6:0] out_rt;
  logic out_writes_rt;
  logic [10:0] out_pc_plus8;
  logic br_valid, br_taken;
  logic [10:0] br_target;
  logic [31:0] perf_stall_cycles, perf_issued;
  typedef struct {
    logic [127:0] ra, rb, rc, imm;
    logic [6:0] rt;
    logic wrt;
    logic [10:0] pc;
  } exp_t;
  typedef struct {
    logic taken;
    logic [10:0] tgt;
  } br_t;
  exp_t q[$];
  br_t bq[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  id_stage_scoreboard dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc_plus8(in_pc_plus8), .in_uses_ra(in_uses_ra),
    .in_uses_rb(in_uses_rb), .in_uses_rc(in_uses_rc), .in_writes_rt(in_writes_rt),
    .in_is_branch(in_is_branch), .in_imm_sel(in_imm_sel), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc), .out_imm(out_imm),
    .out_rt(out_rt), .out_writes_rt(out_writes_rt), .out_pc_plus8(out_pc_plus8),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .perf_stall_cycles(perf_stall_cycles), .perf_issued(perf_issued)
  );
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  // payload monitor: one expectation per accepted output beat
  initial forever begin
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_payload", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_ra", out_ra, e.ra);
        chk("out_rb", out_rb, e.rb);
        chk("out_rc", out_rc, e.rc);
        chk("out_imm", out_imm, e.imm);
        chk("out_rt", 128'(out_rt), 128'(e.rt));
        chk("out_writes_rt", 128'(out_writes_rt), 128'(e.wrt));
        chk("out_pc_plus8", 128'(out_pc_plus8), 128'(e.pc));
      end
    end
  end
  // branch monitor: one expectation per br_valid pulse
  initial forever begin
    @(negedge clk);
    if (!reset && br_valid) begin
      chk("br_with_out_valid", 128'(out_valid), 1);
      if (bq.size() == 0) chk("unexpected_br_valid", 1, 0);
      else begin
        br_t b;
        b = bq.pop_front();
        chk("br_taken", 128'(br_taken), 128'(b.taken));
        chk("br_target", 128'(br_target), 128'(b.tgt));
      end
    end
  end
  task automatic setin(input logic [31:0] instr, input logic [10:0] pc, input logic [4:0] f, input logic [1:0] sel);
    in_valid = 1; in_instr = instr; in_pc_plus8 = pc; in_imm_sel = sel;
    {in_uses_ra, in_uses_rb, in_uses_rc, in_writes_rt, in_is_branch} = f;
  endtask
  task automatic push(input logic [31:0] instr, input logic [10:0] pc, input logic [4:0] f,
                      input logic [127:0] ra, rb, rc, imm);
    exp_t e;
    e.ra = ra; e.rb = rb; e.rc = rc; e.imm = imm; e.rt = instr[6:0]; e.wrt = f[1]; e.pc = pc;
    q.push_back(e);
  endtask
  // drive an instruction and wait (bounded) until it issues; returns stall cycles seen
  task automatic go(input logic [31:0] instr, input logic [10:0] pc, input logic [4:0] f, input logic [1:0] sel,
                    input logic [127:0] ra, rb, rc, imm, input bit do_push, output int w);
    int n;
    bit ok;
    if (do_push) push(instr, pc, f, ra, rb, rc, imm);
    setin(instr, pc, f, sel);
    ok = 0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("issue_timeout", 1, 0);
    w = n;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wb(input logic [6:0] a, input logic [127:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_en = 0;
  endtask
  task automatic pushbr(input logic t, input logic [10:0] g);
    br_t b;
    b.taken = t; b.tgt = g;
    bq.push_back(b);
  endtask
  initial begin
    int w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 0);
    chk("rst_in_ready", 128'(in_ready), 0);
    chk("rst_br_valid", 128'(br_valid), 0);
    chk("rst_br_taken", 128'(br_taken), 0);
    chk("rst_out_ra", out_ra, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_br_target", 128'(br_target), 0);
    @(posedge clk); #1;
    reset = 0;
    wb(7'd5, 128'h1234);
    go(32'h0000_0280, 11'h020, 5'b10000, 2'd0, 128'h1234, 0, 0, 0, 1, w);
    @(negedge clk);
    chk("ready_after_issue", 128'(in_ready), 1);
    @(posedge clk); #1;
    go(32'h0000_0009, 11'h028, 5'b00010, 2'd0, 0, 0, 0, 0, 1, w);
    push(32'h0000_0480, 11'h030, 5'b10000, 128'hAA, 0, 0, 0);
    setin(32'h0000_0480, 11'h030, 5'b10000, 2'd0);
    repeat (3) begin
      @(negedge clk);
      chk("raw_stall_ready", 128'(in_ready), 0);
      @(posedge clk); #1;
    end
    wb_en = 1; wb_addr = 7'd9; wb_data = 128'hAA;
    @(negedge clk);
    chk("bypass_ready", 128'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0; wb_en = 0;
`ifdef ID_PERF_CNT_EN
    @(negedge clk);
    chk("perf_stall", 128'(perf_stall_cycles), 3);
    chk("perf_issued", 128'(perf_issued), 3);
    @(posedge clk); #1;
`endif
    go(32'h0000_0480, 11'h038, 5'b10000, 2'd0, 128'hAA, 0, 0, 0, 1, w);
    out_ready = 0;
    setin(32'h0000_0005, 11'h040, 5'b00100, 2'd0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", 128'(in_ready), 0);
      chk("hold_valid", 128'(out_valid), 1);
      chk("hold_ra", out_ra, 128'hAA);
      chk("hold_pc", 128'(out_pc_plus8), 128'h038);
      @(posedge clk); #1;
    end
    out_ready = 1;
    go(32'h0000_0005, 11'h040, 5'b00100, 2'd0, 0, 0, 128'h1234, 0, 1, w);
    chk("release_wait", 128'(w), 0);
    wb(7'd0, 128'h7);
    wb(7'd4, 128'h7);
    pushbr(1, 11'h030);
    go(32'h0000_0200, 11'h010, 5'b11001, 2'd2, 128'h7, 128'h7, 128'h7, 128'h4, 1, w);
    pushbr(0, 11'h008);
    go(32'h0000_0100, 11'h7F8, 5'b11001, 2'd2, 0, 128'h7, 128'h7, 128'h2, 1, w);
    go(32'h001F_C000, 11'h000, 5'b00000, 2'd0, 128'h7, 0, 128'h7, '1, 1, w);
    go(32'h0080_0000, 11'h000, 5'b00000, 2'd1, 128'h7, 128'h7, 128'h7, ~128'h1FF, 1, w);
    go(32'h0009_1A00, 11'h000, 5'b00000, 2'd2, 0, 0, 128'h7, 128'h1234, 1, w);
    go(32'h01FF_FF80, 11'h000, 5'b00000, 2'd3, 0, 0, 128'h7, 128'h3FFFF, 1, w);
    go(32'h0000_0003, 11'h050, 5'b00010, 2'd0, 0, 0, 0, 0, 0, w);
    out_ready = 0;
    @(negedge clk);
    chk("pre_reset_valid", 128'(out_valid), 1);
    @(posedge clk); #1;
    reset = 1; wb_en = 1; wb_addr = 7'd7; wb_data = 128'h55;
    @(negedge clk);
    chk("reset_ready", 128'(in_ready), 0);
    @(posedge clk); #1;
    reset = 0; wb_en = 0; out_ready = 1;
    @(negedge clk);
    chk("post_reset_valid", 128'(out_valid), 0);
    chk("post_reset_ra", out_ra, 0);
    chk("post_reset_br_valid", 128'(br_valid), 0);
    @(posedge clk); #1;
    go(32'h0001_C180, 11'h060, 5'b11000, 2'd0, 0, 0, 0, 128'h7, 1, w);
    chk("post_reset_wait", 128'(w), 0);
    repeat (4) @(negedge clk);
    chk("payload_queue_empty", 128'(q.size()), 0);
    chk("branch_queue_empty", 128'(bq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_scoreboard.md
Name: id_stage_scoreboard

Overview:
- Parametrised successor to the SPU instruction-decode stage: register file, immediate generation, and branch compare/target, as before.
- Adds a per-register busy scoreboard with RAW/WAW stall, write-through bypass from writeback, and valid/ready handshakes on both sides.
- Output is a registered ID/EX boundary.
- Sits between the IF/ID register and the execute stage.

Parameters:
- DATA_W, 128, register/data width
- NUM_REGS, 128, register count
- REG_AW, 7, register address width (2^REG_AW >= NUM_REGS)
- PC_W, 11, PC/branch address width
- BR_SHIFT, 3, left shift applied to immediate for branch target

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  decode request valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction; RB=[20:14], RA=[13:7], RC/RT=[6:0]
- in_pc_plus8  in  PC_W  PC+8 of instruction
- in_uses_ra / in_uses_rb / in_uses_rc  in  1 each  source operand used
- in_writes_rt  in  1  instruction writes RT
- in_is_branch  in  1  conditional branch (taken when RA==RB)
- in_imm_sel  in  2  0:I7 [20:14] sext, 1:I10 [23:14] sext, 2:I16 [22:7] sext, 3:I18 [24:7] zext
- wb_en  in  1  writeback strobe
- wb_addr  in  REG_AW  writeback register
- wb_data  in  DATA_W  writeback data
- out_valid  out  1  ID/EX payload valid
- out_ready  in  1  execute accepts
- out_ra, out_rb, out_rc  out  DATA_W each  operand data
- out_imm  out  DATA_W  extended immediate
- out_rt  out  REG_AW  destination register
- out_writes_rt  out  1  destination enable
- out_pc_plus8  out  PC_W  forwarded PC+8
- br_valid  out  1  one-cycle branch-resolution pulse
- br_taken  out  1  branch condition true
- br_target  out  PC_W  branch target
- perf_stall_cycles  out  32  stall counter (optional feature)
- perf_issued  out  32  issue counter (optional feature)

Behaviour:
- Reset (sync, high): all registers cleared to 0, all busy bits cleared; out_valid=0, br_valid=0, br_taken=0, and all data outputs 0.
- Register file: one write port (wb). Reads are combinational from in_instr fields. Write-through: a read of wb_addr in the same cycle as wb_en returns wb_data.
- Hazard is 1 when any of:
  - in_uses_ra & busy[RA] & !(wb_en & wb_addr==RA)
  - the same term for RB
  - the same term for RC
  - in_writes_rt & busy[RT] & !(wb_en & wb_addr==RT)
- Handshake:
  - in_ready = !reset & !hazard & (!out_valid | out_ready).
  - Issue = in_valid & in_ready.
- Issue timing:
  - On issue, all out_* register next cycle; out_valid=1. Latency is 1 cycle.
  - If out_valid & !out_ready, all out_* hold stable.
  - If no issue and out_ready, out_valid drops to 0.
- Scoreboard:
  - Issue with in_writes_rt sets busy[RT].
  - wb_en clears busy[wb_addr].
  - Same register set and cleared in one cycle: set wins.
  - wb_en to a non-busy register is legal; register is written, scoreboard is unaffected.
- Branch:
  - On issue with in_is_branch, br_valid pulses 1 cycle later, simultaneous with the out_valid rise.
  - br_taken = (bypassed RA == bypassed RB).
  - br_target = in_pc_plus8 + (imm[PC_W-1:0] << BR_SHIFT), modulo 2^PC_W (wrap-around).
  - br_valid is a pulse even if out_ready is low.
- Immediate: sign or zero extension to DATA_W as selected by in_imm_sel.
- Stall: in_valid & !in_ready holds no state; the upstream stage holds its inputs.
- Reset mid-operation: pending busy bits and the in-flight output are dropped. A writeback in the reset cycle is ignored.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- Defined:
  - perf_stall_cycles increments on every cycle with in_valid & !in_ready.
  - perf_issued increments on every issue.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports tied to 0 and no counter logic.

Test Plan:
- Reset, then write R5=0x1234 via wb, then issue with RA=5, uses_ra -> next cycle out_valid=1, out_ra=0x1234, in_ready stays 1.
- Issue A writing R9; then B reading R9 -> in_ready=0 until wb_en wb_addr=9 wb_data=0xAA. In that same cycle B issues and out_ra=0xAA; stall count=cycles waited (with ID_PERF_CNT_EN).
- out_ready=0 for 3 cycles with valid payload -> out_* stable, in_ready=0; raise out_ready -> next instruction issues.
- Branch, RA=RB=0x7, imm16=0x0004, pc_plus8=0x010 -> br_valid 1 cycle, br_taken=1, br_target=0x030. Repeat with pc_plus8=0x7F8, imm=0x0002 -> br_target=0x008 (wrap).
- in_imm_sel=0 with instr[20:14]=0x7F -> out_imm all ones. in_imm_sel=3 with instr[24:7]=0x3FFFF -> out_imm=0x3FFFF.
- Set busy R3 then assert reset with out_valid=1 -> out_valid=0, busy clear. Instruction reading R3 issues immediately after reset with out_ra=0.
